// File: rtl/branchjumpctrl_if.sv
// Decode-to-control bundle for the branch/jump unit: instruction fields in,
// PC mux code, targets and status out.
interface branchjumpctrl_if;
  logic        instvalid;
  logic        stall;
  logic [31:0] pc;
  logic        isbeq;
  logic        isbne;
  logic        isj;
  logic        isjr;
  logic [15:0] imm16;
  logic [25:0] instrindex;
  logic [31:0] rsdata;
  logic [31:0] rtdata;
  logic [1:0]  branchcode;
  logic [31:0] jumpaddr;
  logic [31:0] branchaddr;
  logic        flush;
  logic        busy;
  logic [15:0] redircount;

  modport master (
    output instvalid, stall, pc, isbeq, isbne, isj, isjr, imm16, instrindex, rsdata, rtdata,
    input  branchcode, jumpaddr, branchaddr, flush, busy, redircount
  );

  modport slave (
    input  instvalid, stall, pc, isbeq, isbne, isj, isjr, imm16, instrindex, rsdata, rtdata,
    output branchcode, jumpaddr, branchaddr, flush, busy, redircount
  );
endinterface

// File: rtl/branchjumpctrl.sv
// Branch/jump control: resolves the decode-stage instruction, presents a
// registered PC mux code plus target, then flushes fetch for FLUSHCYCLES cycles.
module branchjumpctrl #(
  parameter int unsigned FLUSHCYCLES = 1,
  // Saturation ceiling of the redirect counter; all-ones for normal use.
  parameter logic [15:0] REDIR_MAX   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  branchjumpctrl_if.slave  bus
);

  localparam logic [1:0] NOLOAD    = 2'b00;
  localparam logic [1:0] SELJUMP   = 2'b01;
  localparam logic [1:0] SELBRANCH = 2'b10;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSHCYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] jumpaddr_q, jumpaddr_d;
  logic [31:0] branchaddr_q, branchaddr_d;
  logic [15:0] redircount_q, redircount_d;
  logic [2:0]  fcnt_q, fcnt_d;

  logic [31:0] pcplus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        taken;
  logic        is_jump;
  logic [31:0] jump_target;

  // Target formation and winner selection; only the highest-priority flag counts.
  always_comb begin
    pcplus4     = bus.pc + 32'd4;
    br_target   = pcplus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    j_target    = {pcplus4[31:28], bus.instrindex, 2'b00};
    taken       = 1'b0;
    is_jump     = 1'b0;
    jump_target = j_target;
    if (bus.isjr) begin
      taken       = 1'b1;
      is_jump     = 1'b1;
      jump_target = bus.rsdata;
    end else if (bus.isj) begin
      taken   = 1'b1;
      is_jump = 1'b1;
    end else if (bus.isbeq) begin
      taken = (bus.rsdata == bus.rtdata);
    end else if (bus.isbne) begin
      taken = (bus.rsdata != bus.rtdata);
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    jumpaddr_d   = jumpaddr_q;
    branchaddr_d = branchaddr_q;
    redircount_d = redircount_q;
    fcnt_d       = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instvalid && !bus.stall && taken) begin
          state_d = S_ISSUE;
          if (is_jump) begin
            code_d     = SELJUMP;
            jumpaddr_d = jump_target;
          end else begin
            code_d       = SELBRANCH;
            branchaddr_d = br_target;
          end
        end
      end
      S_ISSUE: begin
        // The mux loads the PC on this edge, so the redirect is consumed here.
        if (!bus.stall) begin
          state_d = S_FLUSH;
          code_d  = NOLOAD;
          fcnt_d  = FLUSH_LOAD;
          if (redircount_q != REDIR_MAX) begin
            redircount_d = redircount_q + 16'd1;
          end
        end
      end
      S_FLUSH: begin
        if (!bus.stall) begin
          if (fcnt_q <= 3'd1) begin
            state_d = S_IDLE;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = NOLOAD;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= NOLOAD;
      jumpaddr_q   <= 32'd0;
      branchaddr_q <= 32'd0;
      redircount_q <= 16'd0;
      fcnt_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      jumpaddr_q   <= jumpaddr_d;
      branchaddr_q <= branchaddr_d;
      redircount_q <= redircount_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign bus.branchcode = code_q;
  assign bus.jumpaddr   = jumpaddr_q;
  assign bus.branchaddr = branchaddr_q;
  assign bus.flush      = (state_q != S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.redircount = redircount_q;

endmodule

// File: tb/tb_branchjumpctrl.sv
// Directed bench for branchjumpctrl: one instance with FLUSHCYCLES=1 and one
// with FLUSHCYCLES=3 and a low counter ceiling to reach saturation quickly.
module tb_branchjumpctrl;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branchjumpctrl_if ia ();
  branchjumpctrl_if ib ();

  branchjumpctrl #(.FLUSHCYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia.slave)
  );

  branchjumpctrl #(.FLUSHCYCLES(3), .REDIR_MAX(16'd5)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    ia.instvalid = 0; ia.stall = 0; ia.pc = 0; ia.isbeq = 0; ia.isbne = 0;
    ia.isj = 0; ia.isjr = 0; ia.imm16 = 0; ia.instrindex = 0; ia.rsdata = 0; ia.rtdata = 0;
  endtask

  task automatic clr_b();
    ib.instvalid = 0; ib.stall = 0; ib.pc = 0; ib.isbeq = 0; ib.isbne = 0;
    ib.isj = 0; ib.isjr = 0; ib.imm16 = 0; ib.instrindex = 0; ib.rsdata = 0; ib.rtdata = 0;
  endtask

  initial begin
    int exp_cnt;
    clr_a();
    clr_b();
    rst_a = 1; rst_b = 1;
    step(); step();
    rst_a = 0; rst_b = 0;
    chk("rst_code", 32'(ia.branchcode), 32'd0);
    chk("rst_jaddr", ia.jumpaddr, 32'd0);
    chk("rst_baddr", ia.branchaddr, 32'd0);
    chk("rst_flush", 32'(ia.flush), 32'd0);
    chk("rst_busy", 32'(ia.busy), 32'd0);
    chk("rst_cnt", 32'(ia.redircount), 32'd0);
    step();
    chk("idle_code", 32'(ia.branchcode), 32'd0);

    // Taken beq: 0x104 + (-4 << 2) = 0xF4
    ia.pc = 32'h0000_0100; ia.imm16 = 16'hFFFC; ia.rsdata = 5; ia.rtdata = 5;
    ia.isbeq = 1; ia.instvalid = 1;
    step();
    clr_a();
    chk("beq_code", 32'(ia.branchcode), 32'd2);
    chk("beq_baddr", ia.branchaddr, 32'h0000_00F4);
    chk("beq_flush", 32'(ia.flush), 32'd1);
    chk("beq_busy", 32'(ia.busy), 32'd1);
    step();
    chk("beq_fl_code", 32'(ia.branchcode), 32'd0);
    chk("beq_fl_flush", 32'(ia.flush), 32'd1);
    chk("beq_cnt", 32'(ia.redircount), 32'd1);
    step();
    chk("beq_idle_fl", 32'(ia.flush), 32'd0);
    chk("beq_idle_busy", 32'(ia.busy), 32'd0);

    // Untaken bne
    ia.isbne = 1; ia.rsdata = 7; ia.rtdata = 7; ia.instvalid = 1; ia.pc = 32'h300;
    step();
    chk("bne_code", 32'(ia.branchcode), 32'd0);
    chk("bne_flush", 32'(ia.flush), 32'd0);
    chk("bne_busy", 32'(ia.busy), 32'd0);
    chk("bne_cnt", 32'(ia.redircount), 32'd1);
    clr_a();

    // j beats beq
    ia.isj = 1; ia.isbeq = 1; ia.pc = 32'hA000_0000; ia.instrindex = 26'h0000040;
    ia.rsdata = 1; ia.rtdata = 1; ia.instvalid = 1;
    step();
    clr_a();
    chk("j_code", 32'(ia.branchcode), 32'd1);
    chk("j_jaddr", ia.jumpaddr, 32'hA000_0100);
    chk("j_baddr_keep", ia.branchaddr, 32'h0000_00F4);
    step(); step();

    // jr beats j
    ia.isjr = 1; ia.isj = 1; ia.rsdata = 32'h0040_0020; ia.instrindex = 26'h3FFFFFF;
    ia.instvalid = 1;
    step();
    clr_a();
    chk("jr_code", 32'(ia.branchcode), 32'd1);
    chk("jr_jaddr", ia.jumpaddr, 32'h0040_0020);
    step(); step();
    chk("jr_cnt", 32'(ia.redircount), 32'd3);

    // Stall in IDLE blocks acceptance
    ia.isjr = 1; ia.rsdata = 32'h1234_5678; ia.instvalid = 1; ia.stall = 1;
    step();
    chk("stidle_code", 32'(ia.branchcode), 32'd0);
    chk("stidle_busy", 32'(ia.busy), 32'd0);
    clr_a();

    // Stall in ISSUE: 0x204 + (0x10 << 2) = 0x244
    ia.isbeq = 1; ia.pc = 32'h200; ia.imm16 = 16'h0010; ia.rsdata = 9; ia.rtdata = 9;
    ia.instvalid = 1;
    step();
    chk("st_code0", 32'(ia.branchcode), 32'd2);
    chk("st_baddr0", ia.branchaddr, 32'h0000_0244);
    ia.stall = 1; ia.isbeq = 0; ia.isjr = 1; ia.rsdata = 32'hDEAD_BEEF; ia.pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_code", 32'(ia.branchcode), 32'd2);
      chk("st_baddr", ia.branchaddr, 32'h0000_0244);
      chk("st_jaddr", ia.jumpaddr, 32'h0040_0020);
      chk("st_flush", 32'(ia.flush), 32'd1);
      chk("st_cnt", 32'(ia.redircount), 32'd3);
    end
    clr_a();
    step();
    chk("st_rel_code", 32'(ia.branchcode), 32'd0);
    chk("st_rel_cnt", 32'(ia.redircount), 32'd4);
    step();
    chk("st_rel_idle", 32'(ia.busy), 32'd0);

    // Stall in FLUSH freezes the counter
    ia.isj = 1; ia.instvalid = 1;
    step();
    clr_a();
    step();
    ia.stall = 1;
    step();
    chk("stfl_busy", 32'(ia.busy), 32'd1);
    ia.stall = 0;
    step();
    chk("stfl_done", 32'(ia.busy), 32'd0);
    chk("stfl_cnt", 32'(ia.redircount), 32'd5);

    // Back-to-back jumps: codes 01,00,00,01 (spacing 3)
    ia.isj = 1; ia.instvalid = 1;
    step(); chk("b2b_c0", 32'(ia.branchcode), 32'd1);
    step(); chk("b2b_c1", 32'(ia.branchcode), 32'd0);
    step(); chk("b2b_c2", 32'(ia.branchcode), 32'd0);
    step(); chk("b2b_c3", 32'(ia.branchcode), 32'd1);
    clr_a();
    step(); step();

    // FLUSHCYCLES=3: reset in the second FLUSH cycle
    ib.isj = 1; ib.instvalid = 1; ib.pc = 32'h1000; ib.instrindex = 26'h10;
    step();
    clr_b();
    chk("b_code", 32'(ib.branchcode), 32'd1);
    step();
    chk("b_fl1_cnt", 32'(ib.redircount), 32'd1);
    step();
    chk("b_fl2_busy", 32'(ib.busy), 32'd1);
    rst_b = 1;
    step();
    rst_b = 0;
    chk("b_rst_flush", 32'(ib.flush), 32'd0);
    chk("b_rst_busy", 32'(ib.busy), 32'd0);
    chk("b_rst_cnt", 32'(ib.redircount), 32'd0);
    chk("b_rst_jaddr", ib.jumpaddr, 32'd0);

    // Flush lasts 4 cycles; counter saturates at the ceiling of 5
    for (int r = 1; r <= 7; r++) begin
      exp_cnt = (r < 5) ? r : 5;
      ib.isj = 1; ib.instvalid = 1; ib.pc = 32'(r << 8);
      step();
      clr_b();
      chk("sat_code", 32'(ib.branchcode), 32'd1);
      chk("sat_flush0", 32'(ib.flush), 32'd1);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("sat_flushk", 32'(ib.flush), 32'd1);
      end
      step();
      chk("sat_end", 32'(ib.flush), 32'd0);
      chk("sat_cnt", 32'(ib.redircount), 32'(exp_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branchjumpctrl.md
# branchjumpctrl

Branch and jump control unit that drives the PC address mux. It evaluates branch conditions and forms branch, jump and register-jump targets for the instruction in decode. It then presents a registered 2-bit branch code with matching target addresses to the mux, and holds that code across pipeline stalls. After a redirect it asserts a fetch flush for a configurable number of cycles, and it counts taken redirects.

## Interface
- FLUSHCYCLES, 1: cycles spent in FLUSH after a redirect is consumed; legal range 1..7.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- instvalid  input  1  decode-stage instruction valid this cycle.
- stall  input  1  pipeline stall; PC does not load while high.
- pc  input  32  address of the decode-stage instruction.
- isbeq, isbne, isj, isjr  input  1 each  decoded instruction class flags.
- imm16  input  16  branch offset field.
- instrindex  input  26  jump index field.
- rsdata, rtdata  input  32  register operands for compare and jr target.
- branchcode  output  2  to the mux; NOLOAD=2'b00, SELJUMP=2'b01, SELBRANCH=2'b10, 2'b11 never driven. Codes come from branchcodedef.v.
- jumpaddr  output  32  registered jump target (j or jr).
- branchaddr  output  32  registered branch target.
- flush  output  1  squash wrong-path fetch.
- busy  output  1  high whenever state is not IDLE.
- redircount  output  16  count of issued redirects, saturating.

## Operation
- Targets, combinational from inputs, all modulo 2^32:
  - pcplus4 = pc + 4.
  - branch target = pcplus4 + (sign-extended imm16 << 2).
  - j target = {pcplus4[31:28], instrindex, 2'b00}.
  - jr target = rsdata.
- Taken conditions:
  - beq: rsdata == rtdata.
  - bne: rsdata != rtdata.
  - j and jr: always taken.
- Flag priority when several flags are high: isjr > isj > isbeq > isbne. Only the winning flag is evaluated.
- FSM states: IDLE, ISSUE, FLUSH.
- IDLE:
  - An instruction is accepted when instvalid=1, stall=0 and the winner is taken.
  - On acceptance, register the code, register the target into jumpaddr (jump) or branchaddr (branch), and go to ISSUE.
  - An untaken branch or an absent instruction stays in IDLE with branchcode=NOLOAD.
  - If stall=1, the instruction is not accepted.
- ISSUE:
  - branchcode and the address outputs hold their values and flush=1.
  - With stall=1, remain in ISSUE with no change to any output.
  - With stall=0, the redirect is consumed at this edge: redircount increments (saturating at 16'hFFFF), the flush counter loads FLUSHCYCLES, and the FSM goes to FLUSH.
- FLUSH:
  - branchcode=NOLOAD and flush=1; instvalid is ignored.
  - The counter decrements each non-stalled cycle; stall=1 freezes it.
  - When the counter reaches 1 on a non-stalled edge, go to IDLE.
- Address outputs retain their last value outside ISSUE; only the address selected by branchcode is meaningful.
- Reset values: branchcode=NOLOAD, jumpaddr=0, branchaddr=0, flush=0, busy=0, redircount=0, state=IDLE, flush counter=0.
- Reset mid-operation in any state: every output takes its reset value at the next edge, and any pending redirect is dropped.

## Timing
- Decision latency: an instruction sampled at edge N drives branchcode and the target during cycle N+1. The mux loads the PC at edge N+1 if stall=0.
- The redirect code is visible for at least one cycle, extended by one cycle per stalled cycle in ISSUE.
- With no stalls, flush is high for 1 + FLUSHCYCLES consecutive cycles. busy has the same duration.
- Back-to-back: the earliest next acceptance is the first IDLE cycle after FLUSH. Minimum redirect spacing is 2 + FLUSHCYCLES cycles.
- rst has priority over every other input on the same edge.

## Test plan
- Reset then idle: after rst=1 for 2 cycles, all outputs are 0 and branchcode=2'b00 with instvalid=0.
- Taken beq: pc=32'h0000_0100, imm16=16'hFFFC, rs=rt=5, FLUSHCYCLES=1.
  - Next cycle: branchcode=2'b10, branchaddr=32'h0000_00F4, flush=1.
  - Then one FLUSH cycle, then IDLE.
  - redircount=1.
- Untaken bne: rs=rt=7. branchcode stays 2'b00, flush=0, busy=0, redircount unchanged.
- Priority and jumps:
  - isj=1 and isbeq=1 with pc=32'hA000_0000, instrindex=26'h0000040: branchcode=2'b01, jumpaddr=32'hA000_0100.
  - isjr=1 with rsdata=32'h0040_0020: jumpaddr=32'h0040_0020.
- Stall in ISSUE: hold stall=1 for 3 cycles after acceptance.
  - branchcode=2'b10 persists for 4 cycles.
  - redircount increments once, after stall falls.
  - Inputs changed during the stall do not alter the outputs.
- Reset mid-FLUSH and saturation:
  - With FLUSHCYCLES=3, assert rst in the second FLUSH cycle: next cycle flush=0, busy=0, redircount=0.
  - Preload the count to 16'hFFFF through 65535 redirects: a further redirect keeps it at 16'hFFFF.
